amplitude_tracker: RTL

Multi-channel, windowed amplitude detector for the IAGC loop. It replaces the single-pair peak detector by tracking both the positive and the negative peak of every channel over a programmable window of accepted samples. At the end of each window it reports the half peak-to-peak amplitude of every channel with a one-cycle valid strobe. It sits between the ZMOD sample path and the gain controller, and accepts any number of channels on one shared sample strobe.

---
 rtl/amplitude_tracker.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/amplitude_tracker.sv
// Windowed per-channel peak tracker: reports (max - min) >> 1 for every channel once per window.
// Define AMPLITUDE_TRACKER_OFFSET_EN to add the o_offset port ((max + min) >>> 1 per channel).
module amplitude_tracker #(
  parameter int unsigned N_CHANNELS           = 2,
  parameter int unsigned ZMOD_DATA_SIZE       = 14,
  parameter int unsigned AMPLITUDE_DATA_SIZE  = 14,
  parameter int unsigned AMPLITUDE_COUNT_SIZE = 16
) (
  input  logic                                      i_clock,
  input  logic                                      i_reset,
  input  logic                                      i_enable,
  input  logic                                      i_sample,
  input  logic [N_CHANNELS*ZMOD_DATA_SIZE-1:0]      i_data,
  input  logic [AMPLITUDE_COUNT_SIZE-1:0]           i_window_count,
  output logic [N_CHANNELS*AMPLITUDE_DATA_SIZE-1:0] o_amplitude,
  output logic                                      o_valid,
  output logic                                      o_overrun
`ifdef AMPLITUDE_TRACKER_OFFSET_EN
  ,
  output logic [N_CHANNELS*ZMOD_DATA_SIZE-1:0]      o_offset
`endif
);

  localparam int unsigned N = N_CHANNELS;
  localparam int unsigned W = ZMOD_DATA_SIZE;
  localparam int unsigned A = AMPLITUDE_DATA_SIZE;
  localparam int unsigned C = AMPLITUDE_COUNT_SIZE;

  localparam logic signed [W-1:0] MaxInit = {1'b1, {(W-1){1'b0}}};
  localparam logic signed [W-1:0] MinInit = {1'b0, {(W-1){1'b1}}};

  typedef enum logic [1:0] {StIdle, StAccumulate, StCompute, StValid} state_e;

  state_e                state_q, state_d;
  logic [C-1:0]          count_q, target_q;
  logic signed [W-1:0]   max_q    [N];
  logic signed [W-1:0]   min_q    [N];
  logic signed [W-1:0]   sample_s [N];
  logic [N*A-1:0]        amplitude_q, amplitude_d;
  logic                  overrun_q;
  logic                  latch, init_peaks, accept, publish, drop;
  logic [W:0]            diff;

  always_comb begin
    for (int k = 0; k < N; k++) begin
      sample_s[k] = $signed(i_data[k*W +: W]);
    end
  end

  // Difference taken one bit wider so full-scale swings cannot wrap.
  always_comb begin
    amplitude_d = '0;
    diff        = '0;
    for (int k = 0; k < N; k++) begin
      diff = {max_q[k][W-1], max_q[k]} - {min_q[k][W-1], min_q[k]};
      amplitude_d[k*A +: A] = A'(diff >> 1);
    end
  end

  always_comb begin
    state_d    = state_q;
    latch      = 1'b0;
    init_peaks = 1'b0;
    accept     = 1'b0;
    publish    = 1'b0;
    o_valid    = 1'b0;
    unique case (state_q)
      StIdle: begin
        init_peaks = 1'b1;
        if (i_enable) begin
          latch   = 1'b1;
          state_d = StAccumulate;
        end
      end
      StAccumulate: begin
        if (!i_enable) begin
          state_d = StIdle;
        end else if (i_sample) begin
          accept = 1'b1;
          if (count_q + C'(1) == target_q) state_d = StCompute;
        end
      end
      StCompute: begin
        if (!i_enable) begin
          state_d = StIdle;
        end else begin
          publish = 1'b1;
          state_d = StValid;
        end
      end
      StValid: begin
        o_valid = 1'b1;
        if (i_enable) begin
          init_peaks = 1'b1;
          latch      = 1'b1;
          state_d    = StAccumulate;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Samples landing while the result is being produced are lost.
  assign drop = i_sample && ((state_q == StCompute) || (state_q == StValid));

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q     <= StIdle;
      count_q     <= '0;
      target_q    <= C'(1);
      amplitude_q <= '0;
      overrun_q   <= 1'b0;
      for (int k = 0; k < N; k++) begin
        max_q[k] <= MaxInit;
        min_q[k] <= MinInit;
      end
    end else begin
      state_q <= state_d;
      if (latch) begin
        target_q <= (i_window_count == '0) ? C'(1) : i_window_count;
        count_q  <= '0;
      end else if (accept) begin
        count_q <= count_q + C'(1);
      end
      for (int k = 0; k < N; k++) begin
        if (init_peaks) begin
          max_q[k] <= MaxInit;
          min_q[k] <= MinInit;
        end else if (accept) begin
          if (sample_s[k] > max_q[k]) max_q[k] <= sample_s[k];
          if (sample_s[k] < min_q[k]) min_q[k] <= sample_s[k];
        end
      end
      if (publish) amplitude_q <= amplitude_d;
      if (drop)    overrun_q   <= 1'b1;
    end
  end

  assign o_amplitude = amplitude_q;
  assign o_overrun   = overrun_q;

`ifdef AMPLITUDE_TRACKER_OFFSET_EN
  logic [N*W-1:0]      offset_q, offset_d;
  logic signed [W:0]   sum;

  // Arithmetic shift of the widened sum floors toward minus infinity.
  always_comb begin
    offset_d = '0;
    sum      = '0;
    for (int k = 0; k < N; k++) begin
      sum = $signed({max_q[k][W-1], max_q[k]}) + $signed({min_q[k][W-1], min_q[k]});
      offset_d[k*W +: W] = W'(sum >>> 1);
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      offset_q <= '0;
    end else if (publish) begin
      offset_q <= offset_d;
    end
  end

  assign o_offset = offset_q;
`endif

endmodule
